// File: rtl/lcd_persist_pkg.sv
// Shared types, defaults and blend arithmetic for the LCD persistence stage.
// LCD_PERSIST_ROUND_EN selects round-half-up blending; it is truncating when the macro is undefined.
package lcd_persist_pkg;

    localparam int unsigned H_ACTIVE_DEF = 320;
    localparam int unsigned V_ACTIVE_DEF = 144;
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned CH_W         = 8;

    localparam logic [1:0] W_OFF = 2'd0;
    localparam logic [1:0] W_25  = 2'd1;
    localparam logic [1:0] W_50  = 2'd2;
    localparam logic [1:0] W_75  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        BLEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb_t;

    // One channel: (cur*(4-w) + prev*w) >> 2 in a 10-bit accumulator.
    function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0] cur,
                                                 input logic [CH_W-1:0] prev,
                                                 input logic [1:0]      w);
        logic [2:0] k_cur;
        logic [9:0] acc;
        case (w)
            W_OFF:   k_cur = 3'd4;
            W_25:    k_cur = 3'd3;
            W_50:    k_cur = 3'd2;
            W_75:    k_cur = 3'd1;
            default: k_cur = 3'd4;
        endcase
        acc = 10'(cur) * 10'(k_cur) + 10'(prev) * 10'(3'd4 - k_cur);
`ifdef LCD_PERSIST_ROUND_EN
        acc = acc + 10'd2;
`else
        acc = acc + 10'd0;
`endif
        return acc[9:2];
    endfunction

    function automatic rgb_t blend_px(input rgb_t cur, input rgb_t prev, input logic [1:0] w);
        rgb_t res;
        res.r = blend_ch(cur.r, prev.r, w);
        res.g = blend_ch(cur.g, prev.g, w);
        res.b = blend_ch(cur.b, prev.b, w);
        return res;
    endfunction

endpackage

// File: rtl/lcd_persist_blend_if.sv
// Video stream bundle around the persistence stage: upstream pixels in, delayed pixels out.
interface lcd_persist_blend_if;
    import lcd_persist_pkg::*;

    logic [1:0]      weight;
    logic            ce_pix_in;
    logic            hs_in;
    logic            vs_in;
    logic            hbl_in;
    logic            vbl_in;
    logic [CH_W-1:0] r_in;
    logic [CH_W-1:0] g_in;
    logic [CH_W-1:0] b_in;

    logic            ce_pix;
    logic            hs;
    logic            vs;
    logic            hbl;
    logic            vbl;
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
    logic            locked;

    modport master (
        output weight, ce_pix_in, hs_in, vs_in, hbl_in, vbl_in, r_in, g_in, b_in,
        input  ce_pix, hs, vs, hbl, vbl, r, g, b, locked
    );

    modport slave (
        input  weight, ce_pix_in, hs_in, vs_in, hbl_in, vbl_in, r_in, g_in, b_in,
        output ce_pix, hs, vs, hbl, vbl, r, g, b, locked
    );

endinterface

// File: rtl/lcd_persist_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
module lcd_persist_ram #(
    parameter int unsigned DEPTH = 46080,
    parameter int unsigned DW    = 24,
    parameter int unsigned AW    = 16
) (
    input  logic          clk_vid,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // No reset so the array maps onto block RAM.
    always_ff @(posedge clk_vid) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lcd_persist_blend.sv
// LCD ghosting emulation: blends each active pixel with the previous output frame, 2-cycle latency.
// Build option: LCD_PERSIST_ROUND_EN (rounding inside the blend helper of lcd_persist_pkg).
module lcd_persist_blend
    import lcd_persist_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic              clk_vid,
    input  logic              reset_n,
    lcd_persist_blend_if.slave vid
);

    localparam int unsigned DEPTH    = H_ACTIVE * V_ACTIVE;
    localparam int unsigned RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RGB_W    = 3 * CH_W;
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic              locked_q;
    logic              locked_nxt;
    logic              wr_allow_c;
    logic              blend_allow_c;

    logic [ADDR_W-1:0] addr;
    logic              ovf;
    logic              vbl_prev;
    logic              px_active_c;
    logic              frame_bnd_c;
    logic              addr_full_c;
    logic              rd_en_c;

    logic              s1_ce, s1_hs, s1_vs, s1_hbl, s1_vbl;
    logic              s1_we, s1_blend;
    logic [1:0]        s1_w;
    logic [RAM_AW-1:0] s1_addr;
    rgb_t              s1_rgb;

    logic [RGB_W-1:0]  rd_data;
    rgb_t              prev_c;
    rgb_t              mix_c;

    logic              ce_pix_q, hs_q, vs_q, hbl_q, vbl_q;
    rgb_t              rgb_q;

    assign px_active_c = vid.ce_pix_in & ~vid.hbl_in & ~vid.vbl_in;
    assign frame_bnd_c = vid.ce_pix_in & vid.vbl_in & ~vbl_prev;
    assign addr_full_c = (addr == ADDR_END);
    assign rd_en_c     = px_active_c & ~addr_full_c;

    // State register
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            locked_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            locked_q <= locked_nxt;
        end
    end

    // Next state: only evaluated on a frame boundary
    always_comb begin
        state_nxt = state;
        if (frame_bnd_c) begin
            unique case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   if (addr_full_c && !ovf) state_nxt = BLEND;
                BLEND:   if (!addr_full_c || ovf) state_nxt = PRIME;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        locked_nxt    = 1'b0;
        wr_allow_c    = 1'b0;
        blend_allow_c = 1'b0;
        locked_nxt    = (state_nxt == BLEND);
        wr_allow_c    = (state != IDLE);
        blend_allow_c = (state == BLEND) && (vid.weight != W_OFF);
    end

    // Frame-store address, overflow flag and vblank edge tracking
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            addr     <= '0;
            ovf      <= 1'b0;
            vbl_prev <= 1'b0;
        end else if (vid.ce_pix_in) begin
            vbl_prev <= vid.vbl_in;
            if (frame_bnd_c) begin
                addr <= '0;
                ovf  <= 1'b0;
            end else if (px_active_c) begin
                if (addr_full_c) begin
                    ovf <= 1'b1;
                end else begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

    // Stage 1: align inputs with the RAM read latency
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            s1_ce    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_hbl   <= 1'b1;
            s1_vbl   <= 1'b1;
            s1_rgb   <= '0;
            s1_we    <= 1'b0;
            s1_blend <= 1'b0;
            s1_w     <= W_OFF;
            s1_addr  <= '0;
        end else begin
            s1_ce    <= vid.ce_pix_in;
            s1_hs    <= vid.hs_in;
            s1_vs    <= vid.vs_in;
            s1_hbl   <= vid.hbl_in;
            s1_vbl   <= vid.vbl_in;
            s1_rgb   <= '{r: vid.r_in, g: vid.g_in, b: vid.b_in};
            s1_we    <= rd_en_c & wr_allow_c;
            s1_blend <= rd_en_c & blend_allow_c;
            s1_w     <= vid.weight;
            s1_addr  <= RAM_AW'(addr);
        end
    end

    assign prev_c = rd_data;
    assign mix_c  = s1_blend ? blend_px(s1_rgb, prev_c, s1_w) : s1_rgb;

    // The blended result, not the raw input, is stored so history decays recursively.
    lcd_persist_ram #(
        .DEPTH (DEPTH),
        .DW    (RGB_W),
        .AW    (RAM_AW)
    ) u_ram (
        .clk_vid (clk_vid),
        .we      (s1_we),
        .waddr   (s1_addr),
        .wdata   (mix_c),
        .re      (rd_en_c),
        .raddr   (RAM_AW'(addr)),
        .rdata   (rd_data)
    );

    // Stage 2: registered outputs
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            ce_pix_q <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            hbl_q    <= 1'b1;
            vbl_q    <= 1'b1;
            rgb_q    <= '0;
        end else begin
            ce_pix_q <= s1_ce;
            hs_q     <= s1_hs;
            vs_q     <= s1_vs;
            hbl_q    <= s1_hbl;
            vbl_q    <= s1_vbl;
            rgb_q    <= mix_c;
        end
    end

    assign vid.ce_pix = ce_pix_q;
    assign vid.hs     = hs_q;
    assign vid.vs     = vs_q;
    assign vid.hbl    = hbl_q;
    assign vid.vbl    = vbl_q;
    assign vid.r      = rgb_q.r;
    assign vid.g      = rgb_q.g;
    assign vid.b      = rgb_q.b;
    assign vid.locked = locked_q;

endmodule
